alu_sequencer: RTL

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer_if.sv | 31 +++
 rtl/alu_sequencer.sv | 105 ++++++++++
 2 files changed

// File: rtl/alu_sequencer_if.sv
// rtl/alu_sequencer_if.sv - request, ALU and response signal bundle for alu_sequencer
interface alu_sequencer_if;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_a;
  logic [3:0] req_b;
  logic [2:0] req_sel;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_sel;
  logic [3:0] alu_result;
  logic       alu_carry;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_result;
  logic       rsp_carry;
  logic [2:0] rsp_sel;
  logic [7:0] op_count;

  modport slave (
    input  req_valid, req_a, req_b, req_sel, alu_result, alu_carry, rsp_ready,
    output req_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_result, rsp_carry,
           rsp_sel, op_count
  );

  modport master (
    output req_valid, req_a, req_b, req_sel, alu_result, alu_carry, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_result, rsp_carry,
           rsp_sel, op_count
  );
endinterface

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - queues ALU requests, issues them one at a time to an external ALU
module alu_sequencer #(
  parameter int DEPTH = 4
) (
  input logic           i_clk,
  input logic           i_rst,
  alu_sequencer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] C_FULL = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t          r_state;
  logic [10:0]     r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [PW:0]     r_count;
  logic [3:0]      r_alu_a;
  logic [3:0]      r_alu_b;
  logic [2:0]      r_alu_sel;
  logic            r_rsp_valid;
  logic [3:0]      r_rsp_result;
  logic            r_rsp_carry;
  logic [2:0]      r_rsp_sel;
  logic [7:0]      r_op_count;

  logic            w_full;
  logic            w_push;
  logic            w_pop;

  // Ready depends only on occupancy so the producer never sees a valid->ready loop
  assign w_full        = (r_count == C_FULL);
  assign w_push        = bus.req_valid && !w_full;
  assign w_pop         = (r_state == S_IDLE) && (r_count != '0);
  assign bus.req_ready = !w_full;

  assign bus.alu_a      = r_alu_a;
  assign bus.alu_b      = r_alu_b;
  assign bus.alu_sel    = r_alu_sel;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_result = r_rsp_result;
  assign bus.rsp_carry  = r_rsp_carry;
  assign bus.rsp_sel    = r_rsp_sel;
  assign bus.op_count   = r_op_count;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {bus.req_sel, bus.req_b, bus.req_a};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_sel    <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_carry  <= 1'b0;
      r_rsp_sel    <= '0;
      r_op_count   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            {r_alu_sel, r_alu_b, r_alu_a} <= r_mem[r_rd_ptr];
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_rsp_result <= bus.alu_result;
          r_rsp_sel    <= r_alu_sel;
          // Carry is only meaningful for add/sub; the ALU leaves it undefined otherwise
          r_rsp_carry  <= (r_alu_sel[2:1] == 2'b00) ? bus.alu_carry : 1'b0;
          r_rsp_valid  <= 1'b1;
          r_state      <= S_RESP;
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_op_count  <= r_op_count + 8'd1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
